// File: rtl/ascon_init_fsm.sv
// ---------------------------------------------------------------------------
// ascon_init_fsm
//   Control FSM for the ASCON-128 initialisation phase on the shared
//   permutation datapath. A start request first selects IV||K||N into the
//   permutation input. The FSM then issues NB_ROUNDS round-constant indices,
//   one per cycle, with the state register enabled. It requests the final
//   0^192||K XOR on the last round, and gives a one-cycle end pulse.
//
// Parameters
//   NB_ROUNDS         number of permutation rounds in the phase (1..12)
//
// Ports
//   clock_i           system clock, rising edge
//   resetb_i          asynchronous active-low reset
//   start_i           start request, sampled only while idle
//   round_o[3:0]      round-constant index to the permutation
//   init_state_sel_o  1 = permutation input takes IV||K||N, 0 = state register
//   en_reg_state_o    load enable of the state register
//   en_xor_key_end_o  XOR 0^192||K onto the permutation output
//   busy_o            phase in progress
//   end_o             one-cycle completion pulse
// ---------------------------------------------------------------------------
module ascon_init_fsm #(
   parameter int NB_ROUNDS = 12
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   output logic [3:0] round_o,
   output logic       init_state_sel_o,
   output logic       en_reg_state_o,
   output logic       en_xor_key_end_o,
   output logic       busy_o,
   output logic       end_o
);

   // Round-constant index of the first round; a shortened phase runs the
   // tail of the 12-round schedule, so the last round is always index 11.
   localparam logic [3:0] START_ROUND = 4'(12 - NB_ROUNDS);
   localparam logic [3:0] LAST_CNT    = 4'(NB_ROUNDS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_ROUNDS = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [3:0] round_q, round_d;
   logic       sel_q, sel_d;
   logic       en_q, en_d;
   logic       xor_q, xor_d;
   logic       busy_q, busy_d;
   logic       end_q, end_d;

   // Next-state and counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 4'd0;
            if (start_i) begin
               state_d = S_FIRST;
            end
         end
         S_FIRST: begin
            if (LAST_CNT == 4'd0) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
            end else begin
               state_d = S_ROUNDS;
               cnt_d   = 4'd1;
            end
         end
         S_ROUNDS: begin
            // >= rather than == so a corrupted counter cannot run past the
            // last round index.
            if (cnt_q >= LAST_CNT) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state/counter and registered. They
   // then line up with the state they describe and never follow start_i
   // combinationally.
   always_comb begin
      round_d = START_ROUND + cnt_d;
      sel_d   = (state_d == S_FIRST);
      en_d    = (state_d == S_FIRST) || (state_d == S_ROUNDS);
      xor_d   = en_d && (cnt_d == LAST_CNT);
      busy_d  = en_d;
      end_d   = (state_d == S_DONE);
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         round_q <= 4'd0;
         sel_q   <= 1'b0;
         en_q    <= 1'b0;
         xor_q   <= 1'b0;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         round_q <= round_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         xor_q   <= xor_d;
         busy_q  <= busy_d;
         end_q   <= end_d;
      end
   end

   assign round_o          = round_q;
   assign init_state_sel_o = sel_q;
   assign en_reg_state_o   = en_q;
   assign en_xor_key_end_o = xor_q;
   assign busy_o           = busy_q;
   assign end_o            = end_q;

endmodule

// File: doc/ascon_init_fsm.md
Name: ascon_init_fsm

Overview:
Control FSM that sequences the ASCON-128 initialisation phase on the shared permutation datapath.
- On a start request it selects the initial state IV||K||N into the permutation input.
- It issues NB_ROUNDS round indices, one per cycle, with the state register enabled.
- It asserts the final key XOR on the last round and returns a one-cycle end pulse.
- It sits between the top-level start/end handshake and the permutation/state-register datapath.

Parameters:
NB_ROUNDS, 12, number of permutation rounds in the phase; legal range 1..12.
START_ROUND, 12-NB_ROUNDS, round-constant index of the first round; derived, not overridden.

Ports:
clock_i  in  1  system clock, rising edge
resetb_i  in  1  asynchronous active-low reset
start_i  in  1  start request, sampled only in IDLE
round_o  out  4  round-constant index to the permutation
init_state_sel_o  out  1  1 = permutation input mux selects IV||K||N; 0 = selects state register
en_reg_state_o  out  1  load enable of the state register
en_xor_key_end_o  out  1  XOR 0^192||K onto the permutation output before the register
busy_o  out  1  phase in progress
end_o  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clock_i. Reset resetb_i is asynchronous and active-low.
- Reset values: state=IDLE, counter=0, round_o=0, every 1-bit output=0.
- Output timing: outputs are Moore-decoded from state and counter, so no output depends combinationally on start_i. The counter is 4 bits; round_o = START_ROUND + counter.
- State IDLE:
  - All outputs 0; round_o = START_ROUND.
  - start_i=1 at a rising edge -> FIRST, counter=0.
- State FIRST (one cycle):
  - init_state_sel_o=1, en_reg_state_o=1, busy_o=1, round_o=START_ROUND.
  - If NB_ROUNDS=1: en_xor_key_end_o=1 and next state is DONE.
  - Otherwise next state is ROUNDS, counter=1.
- State ROUNDS:
  - init_state_sel_o=0, en_reg_state_o=1, busy_o=1.
  - en_xor_key_end_o=1 only when counter=NB_ROUNDS-1, i.e. round_o=11.
  - At counter=NB_ROUNDS-1 -> DONE, counter=0; otherwise counter+1.
- State DONE (one cycle):
  - end_o=1, busy_o=0, en_reg_state_o=0.
  - Next state is IDLE unconditionally.
- Latency: start sampled at edge E0. FIRST occupies the cycle after E0. The last round occupies cycle NB_ROUNDS. end_o is high during cycle NB_ROUNDS+1, i.e. 13 cycles after E0 for NB_ROUNDS=12.
- start_i while busy (FIRST/ROUNDS/DONE): ignored, not queued.
- start_i held high continuously: a new run starts on the edge leaving IDLE. Runs are therefore separated by exactly DONE + one IDLE cycle.
- The counter never exceeds NB_ROUNDS-1 and never wraps; round_o never exceeds 11.
- Reset asserted mid-run: immediate return to IDLE with reset values, and no end_o pulse. The state register contents are a don't-care for this block.
- Illegal/unreachable state encodings recover to IDLE on the next edge.

Test Plan:
1. Reset: resetb_i=0 asynchronously mid-cycle -> all outputs 0 and round_o=0 immediately, without waiting for a clock edge.
2. Nominal, NB_ROUNDS=12: release reset, then a 1-cycle start_i pulse -> round_o = 0,1,...,11 over 12 consecutive cycles with en_reg_state_o=1.
   - init_state_sel_o=1 only in the round-0 cycle.
   - en_xor_key_end_o=1 only in the round-11 cycle.
   - end_o=1 for exactly one cycle, 13 cycles after the start edge.
   - busy_o=1 for exactly 12 cycles.
3. Start during busy: second start pulse at round 5 -> sequence unchanged, single end_o, no second run afterwards.
4. start_i held high for 40 cycles -> repeated runs of 12 busy cycles.
   - end_o pulses at cycles 13 and 27 after the first start edge.
   - One IDLE cycle between each DONE and the following FIRST.
5. Reset mid-run: resetb_i low during round 7 -> outputs 0 at once, no end_o. A new start then gives a complete 0..11 sequence.
6. NB_ROUNDS=6 instance: start pulse -> round_o = 6..11, init_state_sel_o only at round 6, en_xor_key_end_o only at round 11, end_o 7 cycles after the start edge. NB_ROUNDS=1 instance: FIRST cycle has round_o=11, init_state_sel_o=1 and en_xor_key_end_o=1; end_o 2 cycles after the start edge.
